// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - one-hot access size encodings (SZ_WORD / SZ_HALF / SZ_BYTE)
//   - responder FSM state type (IDLE, RD, RESP, WR)
//   - helpers for size legality, alignment, byte-lane enables,
//     store-data lane replication and load-data extension
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [2:0] SZ_WORD = 3'b100;
   localparam logic [2:0] SZ_HALF = 3'b010;
   localparam logic [2:0] SZ_BYTE = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      RESP = 2'd2,
      WR   = 2'd3
   } state_t;

   // Only the three one-hot codes describe a real access.
   function automatic logic size_legal(input logic [2:0] size);
      logic ok;
      case (size)
         SZ_WORD, SZ_HALF, SZ_BYTE: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   // A half must sit on an even address, a word on a multiple of four.
   function automatic logic misaligned(input logic [2:0] size,
                                       input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Little-endian byte-lane enables. Halves select lanes by addr[1] only,
   // words always use all four lanes regardless of the low address bits.
   function automatic logic [3:0] lane_en(input logic [2:0] size,
                                          input logic [1:0] lo);
      logic [3:0] en;
      case (size)
         SZ_BYTE: en = 4'b0001 << lo;
         SZ_HALF: en = lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: en = 4'b1111;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

   // Store data arrives right-aligned; copying it onto every lane lets the
   // byte enables alone pick which lanes land in the RAM.
   function automatic logic [31:0] store_replicate(input logic [2:0]  size,
                                                   input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // Pick the addressed byte/half out of the RAM word and extend it.
   // Word loads pass straight through and ignore the sign request.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{sgn & b[7]}}, b};
         SZ_HALF: r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, DEPTH x 32 bits, four byte-write enables,
// registered read data (read-before-write), contents not reset.
// Each byte lane is its own array so every lane maps onto a plain
// byte-wide block RAM with a simple write enable.
// Ports:
//   clk    in   clock
//   addr   in   word index [AW-1:0]
//   we     in   byte-lane write enables [3:0], lane k = bits [8k+7:8k]
//   wdata  in   write data [31:0]
//   rdata  out  registered read data [31:0] (word at addr on previous edge)
// -----------------------------------------------------------------------------
module dmem_ram #(
   parameter int AW    = 10,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;

         always_ff @(posedge clk) begin
            if (we[gi]) begin
               mem[addr] <= wdata[8*gi +: 8];
            end
            q_reg <= mem[addr];
         end

         assign rdata[8*gi +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory side of the CPU DM_* load/store interface. One byte/half/word access
// per DM_req strobe; stores go through byte lanes, loads come back sign- or
// zero-extended. Every accepted access ends in a one-cycle DM_ready pulse;
// rejected accesses pulse DM_err together with DM_ready.
//
// Timing (edge 1 = edge that samples DM_req in IDLE):
//   read  : IDLE -> RD -> RESP -> IDLE, DM_ready/DM_rdata after edge 3
//   write : IDLE -> WR -> IDLE, lanes committed and DM_ready after edge 2
//   error : IDLE -> RESP -> IDLE, DM_ready+DM_err after edge 2
// DM_req outside IDLE is ignored.
//
// Build option: define DMEM_MISALIGN_TRAP_EN to reject misaligned halves
// (addr[0]=1) and words (addr[1:0]!=0) through the error path. Without it,
// halves use addr[1] only and words ignore addr[1:0].
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   DM_req    in   single-cycle access strobe
//   DM_R      in   read access
//   DM_W      in   write access
//   DM_sign   in   sign-extend sub-word loads
//   DM_size   in   one-hot size: 100 word, 010 half, 001 byte
//   DM_addr   in   byte address [ADDR_W-1:0]
//   DM_wdata  in   right-aligned store data [31:0]
//   DM_rdata  out  last successful load value [31:0]
//   DM_ready  out  one-cycle completion pulse
//   DM_err    out  one-cycle rejection pulse (with DM_ready)
// -----------------------------------------------------------------------------
import dmem_pkg::*;

module dmem_responder #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 2**(ADDR_W-2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DM_req,
   input  logic              DM_R,
   input  logic              DM_W,
   input  logic              DM_sign,
   input  logic [2:0]        DM_size,
   input  logic [ADDR_W-1:0] DM_addr,
   input  logic [31:0]       DM_wdata,
   output logic [31:0]       DM_rdata,
   output logic              DM_ready,
   output logic              DM_err
);

   state_t              state_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [2:0]          size_reg;
   logic                sign_reg;
   logic [31:0]         wdata_reg;
   logic                err_flag_reg;   // request was rejected at capture

   logic [31:0]         rdata_reg;
   logic                ready_reg;
   logic                err_reg;

   logic                req_legal;
   logic [3:0]          ram_we;
   logic [31:0]         ram_wdata;
   logic [31:0]         ram_rdata;

   // ---------------------------------------------------------------------
   // Request legality: exactly one of R/W, and a one-hot size.
   // ---------------------------------------------------------------------
   always_comb begin
      req_legal = (DM_R ^ DM_W) && size_legal(DM_size);
`ifdef DMEM_MISALIGN_TRAP_EN
      if (misaligned(DM_size, DM_addr[1:0])) begin
         req_legal = 1'b0;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // RAM port. The address always follows the captured request: in RD the
   // word is read at the edge leaving RD and is ready during RESP; in WR the
   // lanes are written at the edge leaving WR. A reset on that same edge
   // must kill the store, hence the rst term on the enables.
   // ---------------------------------------------------------------------
   always_comb begin
      ram_we = 4'b0000;
      if (state_reg == WR && !rst) begin
         ram_we = lane_en(size_reg, addr_reg[1:0]);
      end
      ram_wdata = store_replicate(size_reg, wdata_reg);
   end

   dmem_ram #(
      .AW    (ADDR_W-2),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .addr  (addr_reg[ADDR_W-1:2]),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // ---------------------------------------------------------------------
   // Responder FSM with registered outputs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         size_reg     <= SZ_WORD;
         sign_reg     <= 1'b0;
         wdata_reg    <= '0;
         err_flag_reg <= 1'b0;
         rdata_reg    <= '0;
         ready_reg    <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         // Both strobes are single-cycle pulses by default.
         ready_reg <= 1'b0;
         err_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (DM_req) begin
                  addr_reg  <= DM_addr;
                  size_reg  <= DM_size;
                  sign_reg  <= DM_sign;
                  wdata_reg <= DM_wdata;
                  if (!req_legal) begin
                     // Rejected requests skip the RAM entirely.
                     err_flag_reg <= 1'b1;
                     state_reg    <= RESP;
                  end else begin
                     err_flag_reg <= 1'b0;
                     state_reg    <= DM_R ? RD : WR;
                  end
               end
            end

            RD: begin
               state_reg <= RESP;
            end

            RESP: begin
               ready_reg <= 1'b1;
               err_reg   <= err_flag_reg;
               // A rejected access leaves the previous load value visible.
               if (!err_flag_reg) begin
                  rdata_reg <= load_extend(ram_rdata, size_reg, sign_reg,
                                           addr_reg[1:0]);
               end
               state_reg <= IDLE;
            end

            WR: begin
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign DM_rdata = rdata_reg;
   assign DM_ready = ready_reg;
   assign DM_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A byte-array memory model plus a
// "last load value" register predict every response; expected latencies are
// 3 edges for loads and 2 for stores and rejected requests, counted from the
// edge that samples DM_req. Honours DMEM_MISALIGN_TRAP_EN the same way as
// the design build.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int ADDR_W = 12;
   localparam int REGION = 128;   // bytes exercised by the bench

   logic              clk;
   logic              rst;
   logic              DM_req;
   logic              DM_R;
   logic              DM_W;
   logic              DM_sign;
   logic [2:0]        DM_size;
   logic [ADDR_W-1:0] DM_addr;
   logic [31:0]       DM_wdata;
   logic [31:0]       DM_rdata;
   logic              DM_ready;
   logic              DM_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mm [REGION];     // reference memory, byte granular
   logic [31:0] exp_rdata;       // reference for DM_rdata

   dmem_responder #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .DM_req   (DM_req),
      .DM_R     (DM_R),
      .DM_W     (DM_W),
      .DM_sign  (DM_sign),
      .DM_size  (DM_size),
      .DM_addr  (DM_addr),
      .DM_wdata (DM_wdata),
      .DM_rdata (DM_rdata),
      .DM_ready (DM_ready),
      .DM_err   (DM_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   function automatic int nbytes(input logic [2:0] size);
      if (size == 3'b001) return 1;
      if (size == 3'b010) return 2;
      if (size == 3'b100) return 4;
      return 0;
   endfunction

   function automatic bit model_legal(input logic r, input logic w,
                                      input logic [2:0] size,
                                      input logic [11:0] addr);
      int n;
      n = nbytes(size);
      if (r == w || n == 0) return 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((int'(addr) % n) != 0) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // Base byte of the access: naturally aligned down to the access size.
   function automatic int model_base(input logic [11:0] addr, input int n);
      return (int'(addr) / n) * n;
   endfunction

   task automatic model_store(input logic [11:0] addr, input logic [2:0] size,
                              input logic [31:0] wd);
      int n, base;
      n    = nbytes(size);
      base = model_base(addr, n) % REGION;
      for (int i = 0; i < n; i++) mm[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
   endtask

   function automatic logic [31:0] model_load(input logic [11:0] addr,
                                              input logic [2:0] size,
                                              input logic sgn);
      int n, base;
      longint v;
      n    = nbytes(size);
      base = model_base(addr, n) % REGION;
      v    = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mm[base + i]) << (8 * i));
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   // ------------------------------------------------------------------
   // Drive one request (called at posedge+#1) and observe 8 edges.
   // lat = edge number of first DM_ready (0 if none), nready = pulses seen.
   // repulse re-asserts DM_req through the following (busy) edge.
   // ------------------------------------------------------------------
   task automatic xact(input logic r, input logic w, input logic sgn,
                       input logic [2:0] size, input logic [11:0] addr,
                       input logic [31:0] wd, input bit repulse,
                       output int lat, output logic [31:0] rd,
                       output logic err, output int nready);
      lat = 0; rd = '0; err = 1'b0; nready = 0;
      DM_req = 1'b1; DM_R = r; DM_W = w; DM_sign = sgn;
      DM_size = size; DM_addr = addr; DM_wdata = wd;
      @(posedge clk); #1;
      if (repulse) begin
         DM_R = 1'b1; DM_W = 1'b0; DM_addr = addr ^ 12'h004;
      end else begin
         DM_req = 1'b0;
      end
      for (int k = 2; k <= 8; k++) begin
         @(posedge clk); #1;
         DM_req = 1'b0;
         if (DM_ready) begin
            nready++;
            if (lat == 0) begin
               lat = k; rd = DM_rdata; err = DM_err;
            end
         end
      end
      $display("xact r=%0b w=%0b sign=%0b size=%03b addr=0x%03h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0b readies=%0d",
               r, w, sgn, size, addr, wd, lat, rd, err, nready);
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1; DM_req = 1'b0; DM_R = 1'b0; DM_W = 1'b0; DM_sign = 1'b0;
      DM_size = 3'b100; DM_addr = '0; DM_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp_rdata = 32'h0;
      checks++; if (DM_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", DM_ready); end
      checks++; if (DM_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", DM_err); end
      checks++; if (DM_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=0x%08h want=0x00000000", DM_rdata); end
   endtask

   task automatic test_init_region;
      int lat, nr; logic [31:0] rd; logic err; logic [31:0] wd;
      for (int a = 0; a < REGION; a += 4) begin
         wd = $urandom;
         xact(1'b0, 1'b1, 1'b0, 3'b100, 12'(a), wd, 1'b0, lat, rd, err, nr);
         model_store(12'(a), 3'b100, wd);
         checks++; if (lat != 2 || err !== 1'b0 || rd !== exp_rdata) begin
            failures++; $display("FAIL init_store addr=0x%03h got lat=%0d err=%0b rdata=0x%08h want lat=2 err=0 rdata=0x%08h", a, lat, err, rd, exp_rdata);
         end
      end
   endtask

   task automatic test_word;
      int lat, nr; logic [31:0] rd; logic err;
      xact(1'b0, 1'b1, 1'b0, 3'b100, 12'h010, 32'hDEADBEEF, 1'b0, lat, rd, err, nr);
      model_store(12'h010, 3'b100, 32'hDEADBEEF);
      checks++; if (lat != 2) begin failures++; $display("FAIL sw_latency got=%0d want=2", lat); end
      checks++; if (rd !== exp_rdata) begin failures++; $display("FAIL sw_rdata_held got=0x%08h want=0x%08h", rd, exp_rdata); end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'h0, 1'b0, lat, rd, err, nr);
      exp_rdata = 32'hDEADBEEF;
      checks++; if (lat != 3) begin failures++; $display("FAIL lw_latency got=%0d want=3", lat); end
      checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL lw_data got=0x%08h err=%0b want=0xDEADBEEF err=0", rd, err); end
   endtask

   task automatic test_byte_lanes;
      int lat, nr; logic [31:0] rd; logic err;
      xact(1'b0, 1'b1, 1'b0, 3'b001, 12'h011, 32'h00000080, 1'b0, lat, rd, err, nr);
      model_store(12'h011, 3'b001, 32'h00000080);
      checks++; if (lat != 2 || err !== 1'b0) begin failures++; $display("FAIL sb got lat=%0d err=%0b want lat=2 err=0", lat, err); end
      xact(1'b1, 1'b0, 1'b1, 3'b001, 12'h011, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=0x%08h want=0xFFFFFF80", rd); end
      xact(1'b1, 1'b0, 1'b0, 3'b001, 12'h011, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=0x%08h want=0x00000080", rd); end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'hDEAD80EF) begin failures++; $display("FAIL lw_after_sb got=0x%08h want=0xDEAD80EF", rd); end
      exp_rdata = 32'hDEAD80EF;
   endtask

   task automatic test_half_lanes;
      int lat, nr; logic [31:0] rd; logic err;
      xact(1'b0, 1'b1, 1'b0, 3'b010, 12'h012, 32'h00008001, 1'b0, lat, rd, err, nr);
      model_store(12'h012, 3'b010, 32'h00008001);
      checks++; if (lat != 2 || rd !== exp_rdata) begin failures++; $display("FAIL sh got lat=%0d rdata=0x%08h want lat=2 rdata=0x%08h", lat, rd, exp_rdata); end
      xact(1'b1, 1'b0, 1'b1, 3'b010, 12'h012, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=0x%08h want=0xFFFF8001", rd); end
      xact(1'b1, 1'b0, 1'b0, 3'b010, 12'h012, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu got=0x%08h want=0x00008001", rd); end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'h800180EF) begin failures++; $display("FAIL lw_after_sh got=0x%08h want=0x800180EF", rd); end
      exp_rdata = 32'h800180EF;
   endtask

   task automatic test_illegal;
      int lat, nr; logic [31:0] rd; logic err;
      logic [2:0] bad_size [3];
      logic       bad_r    [3];
      logic       bad_w    [3];
      bad_size = '{3'b100, 3'b011, 3'b010};
      bad_r    = '{1'b1, 1'b1, 1'b0};
      bad_w    = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         xact(bad_r[i], bad_w[i], 1'b0, bad_size[i], 12'h010, 32'h12345678, 1'b0, lat, rd, err, nr);
         checks++; if (lat != 2 || err !== 1'b1 || nr != 1) begin
            failures++; $display("FAIL illegal_%0d_resp got lat=%0d err=%0b readies=%0d want lat=2 err=1 readies=1", i, lat, err, nr);
         end
         checks++; if (rd !== exp_rdata) begin failures++; $display("FAIL illegal_%0d_rdata got=0x%08h want=0x%08h", i, rd, exp_rdata); end
      end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'h0, 1'b0, lat, rd, err, nr);
      checks++; if (rd !== 32'h800180EF || err !== 1'b0) begin failures++; $display("FAIL illegal_ram_untouched got=0x%08h err=%0b want=0x800180EF err=0", rd, err); end
   endtask

   task automatic test_busy;
      int lat, nr; logic [31:0] rd; logic err;
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h010, 32'h0, 1'b1, lat, rd, err, nr);
      checks++; if (nr != 1) begin failures++; $display("FAIL busy_single_ready got=%0d want=1", nr); end
      checks++; if (lat != 3 || rd !== 32'h800180EF) begin failures++; $display("FAIL busy_load got lat=%0d rdata=0x%08h want lat=3 rdata=0x800180EF", lat, rd); end
   endtask

   task automatic test_reset_mid;
      int lat, nr; logic [31:0] rd; logic err; logic [31:0] prior;
      prior = model_load(12'h020, 3'b100, 1'b0);
      // Store with reset on its commit edge (edge 2).
      DM_req = 1'b1; DM_R = 1'b0; DM_W = 1'b1; DM_size = 3'b100;
      DM_addr = 12'h020; DM_wdata = ~prior;
      @(posedge clk); #1 DM_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_rdata = 32'h0;
      checks++; if (DM_ready !== 1'b0 || DM_err !== 1'b0 || DM_rdata !== 32'h0) begin
         failures++; $display("FAIL rst_mid_outputs got ready=%0b err=%0b rdata=0x%08h want 0 0 0x00000000", DM_ready, DM_err, DM_rdata);
      end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h020, 32'h0, 1'b0, lat, rd, err, nr);
      exp_rdata = prior;
      checks++; if (rd !== prior || lat != 3) begin failures++; $display("FAIL rst_store_suppressed got=0x%08h lat=%0d want=0x%08h lat=3", rd, lat, prior); end
      // Load interrupted by reset before it completes: no ready at all.
      DM_req = 1'b1; DM_R = 1'b1; DM_W = 1'b0; DM_addr = 12'h010;
      @(posedge clk); #1 DM_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      nr = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (DM_ready) nr++;
      end
      exp_rdata = 32'h0;
      checks++; if (nr != 0 || DM_rdata !== 32'h0) begin failures++; $display("FAIL rst_read_no_ready got readies=%0d rdata=0x%08h want 0 0x00000000", nr, DM_rdata); end
   endtask

   task automatic test_misalign;
      int lat, nr; logic [31:0] rd; logic err;
      xact(1'b1, 1'b0, 1'b0, 3'b001, 12'h011, 32'h0, 1'b0, lat, rd, err, nr);
      exp_rdata = 32'h00000080;
      checks++; if (rd !== exp_rdata) begin failures++; $display("FAIL misalign_pre got=0x%08h want=0x00000080", rd); end
      xact(1'b1, 1'b0, 1'b0, 3'b100, 12'h012, 32'h0, 1'b0, lat, rd, err, nr);
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (err !== 1'b1 || lat != 2 || rd !== 32'h00000080) begin failures++; $display("FAIL misalign_lw got err=%0b lat=%0d rdata=0x%08h want err=1 lat=2 rdata=0x00000080", err, lat, rd); end
`else
      checks++; if (err !== 1'b0 || lat != 3 || rd !== 32'h800180EF) begin failures++; $display("FAIL misalign_lw got err=%0b lat=%0d rdata=0x%08h want err=0 lat=3 rdata=0x800180EF", err, lat, rd); end
      exp_rdata = 32'h800180EF;
`endif
   endtask

   task automatic test_random;
      int lat, nr, want_lat; logic [31:0] rd, want; logic err;
      logic r, w, sgn; logic [2:0] size; logic [11:0] addr; logic [31:0] wd;
      bit legal;
      for (int t = 0; t < 150; t++) begin
         w    = ($urandom_range(0, 1) == 1);
         r    = !w;
         sgn  = $urandom_range(0, 1) == 1;
         addr = 12'($urandom_range(0, REGION - 1));
         wd   = $urandom;
         case ($urandom_range(0, 3))
            0:       size = 3'b001;
            1:       size = 3'b010;
            2:       size = 3'b100;
            default: size = 3'($urandom_range(0, 7));
         endcase
         if ($urandom_range(0, 15) == 0) begin r = 1'b1; w = 1'b1; end
         legal = model_legal(r, w, size, addr);
         xact(r, w, sgn, size, addr, wd, 1'b0, lat, rd, err, nr);
         if (!legal) begin
            want_lat = 2;
         end else if (w) begin
            want_lat = 2;
            model_store(addr, size, wd);
         end else begin
            want_lat = 3;
            exp_rdata = model_load(addr, size, sgn);
         end
         want = exp_rdata;
         checks++; if (lat != want_lat || nr != 1 || err !== !legal || rd !== want) begin
            failures++; $display("FAIL random_%0d got lat=%0d readies=%0d err=%0b rdata=0x%08h want lat=%0d readies=1 err=%0b rdata=0x%08h",
                                 t, lat, nr, err, rd, want_lat, !legal, want);
         end
      end
   endtask

   // Safety net: the scenarios are bounded, this only catches a stuck clock.
   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_region();
      test_word();
      test_byte_lanes();
      test_half_lanes();
      test_illegal();
      test_busy();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
